// File: rtl/matvec_sequencer.sv
// Sequences one 8x8 matrix-vector pass: fetch, lockstep FIFO drain into the MAC lanes, flush, capture.
// done 4+N+MAC_LAT cycles after start when fetch is ready; each cycle with any FIFO empty stalls STREAM by one.
module matvec_sequencer #(
    parameter int N             = 8,
    parameter int ACC_W         = 24,
    parameter int MAC_LAT       = 1,
    parameter int FETCH_TIMEOUT = 1024
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               start,
    output logic               busy,
    output logic               done,
    output logic               error,
    output logic               fetch_start,
    input  logic               fetch_done,
    input  logic [N-1:0]       fifo_empty_a,
    input  logic               fifo_empty_b,
    output logic [N-1:0]       fifo_rden_a,
    output logic               fifo_rden_b,
    output logic               mac_clr,
    output logic               mac_en,
    input  logic [N*ACC_W-1:0] mac_result,
    output logic [N*ACC_W-1:0] result
);
    localparam int RD_W  = $clog2(N) + 1;
    localparam int TMO_W = $clog2(FETCH_TIMEOUT) + 1;
    localparam int FL_W  = $clog2(MAC_LAT + 1) + 1;

    typedef enum logic [2:0] {
        IDLE, CLEAR, FETCH, STREAM, FLUSH, DONE, ERROR
    } state_t;

    state_t            state;
    logic [RD_W-1:0]   rd_cnt;
    logic [TMO_W-1:0]  tmo_cnt;
    logic [FL_W-1:0]   flush_cnt;
    logic              rd_ok;
    logic              rd_go;

    // Read enables follow the empty flags in the same cycle so a stall costs exactly one cycle.
    assign rd_ok       = ~(|fifo_empty_a) & ~fifo_empty_b;
    assign rd_go       = (state == STREAM) && rd_ok && (rd_cnt < RD_W'(N));
    assign fifo_rden_b = rd_go;
    assign fifo_rden_a = {N{rd_go}};

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= IDLE;
            busy        <= 1'b0;
            done        <= 1'b0;
            error       <= 1'b0;
            fetch_start <= 1'b0;
            mac_clr     <= 1'b0;
            mac_en      <= 1'b0;
            rd_cnt      <= '0;
            tmo_cnt     <= '0;
            flush_cnt   <= '0;
            result      <= '0;
        end else begin
            fetch_start <= 1'b0;
            mac_clr     <= 1'b0;
            // FIFO q lags rden by one cycle, so the MAC enable is rden delayed.
            mac_en      <= rd_go;
            case (state)
                IDLE, DONE, ERROR: begin
                    if (start) begin
                        state       <= CLEAR;
                        busy        <= 1'b1;
                        done        <= 1'b0;
                        error       <= 1'b0;
                        fetch_start <= 1'b1;
                        mac_clr     <= 1'b1;
                    end
                end
                CLEAR: begin
                    rd_cnt    <= '0;
                    tmo_cnt   <= '0;
                    flush_cnt <= '0;
                    state     <= FETCH;
                end
                FETCH: begin
                    if (fetch_done) begin
                        state <= STREAM;
                    end else if (tmo_cnt == TMO_W'(FETCH_TIMEOUT - 1)) begin
                        state <= ERROR;
                        busy  <= 1'b0;
                        error <= 1'b1;
                    end else begin
                        tmo_cnt <= tmo_cnt + 1'b1;
                    end
                end
                STREAM: begin
                    if (rd_go) begin
                        rd_cnt <= rd_cnt + 1'b1;
                        if (rd_cnt == RD_W'(N - 1))
                            state <= FLUSH;
                    end
                end
                FLUSH: begin
                    if (flush_cnt == FL_W'(MAC_LAT)) begin
                        result <= mac_result;
                        state  <= DONE;
                        busy   <= 1'b0;
                        done   <= 1'b1;
                    end else begin
                        flush_cnt <= flush_cnt + 1'b1;
                    end
                end
                default: begin
                    state <= IDLE;
                    busy  <= 1'b0;
                    done  <= 1'b0;
                    error <= 1'b0;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_matvec_sequencer.sv
// Bench for matvec_sequencer with a behavioural FIFO bank and a one-cycle-latency MAC array.
module tb_matvec_sequencer;
    localparam int N     = 8;
    localparam int ACC_W = 24;
    localparam int FT    = 16;
    localparam int DEPTH = 16;

    logic               clk = 1'b0;
    logic               rst_n;
    logic               start;
    logic               busy, done, error, fetch_start;
    logic               fetch_done;
    logic [N-1:0]       fifo_empty_a;
    logic               fifo_empty_b;
    logic [N-1:0]       fifo_rden_a;
    logic               fifo_rden_b;
    logic               mac_clr, mac_en;
    logic [N*ACC_W-1:0] mac_result;
    logic [N*ACC_W-1:0] result;

    matvec_sequencer #(.N(N), .ACC_W(ACC_W), .MAC_LAT(1), .FETCH_TIMEOUT(FT)) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .busy(busy), .done(done), .error(error),
        .fetch_start(fetch_start), .fetch_done(fetch_done),
        .fifo_empty_a(fifo_empty_a), .fifo_empty_b(fifo_empty_b),
        .fifo_rden_a(fifo_rden_a), .fifo_rden_b(fifo_rden_b),
        .mac_clr(mac_clr), .mac_en(mac_en), .mac_result(mac_result), .result(result)
    );

    always #5 clk = ~clk;

    // FIFO contents and MAC model
    logic [7:0]       fa [N][DEPTH];
    logic [7:0]       fb [DEPTH];
    logic [7:0]       qa [N];
    logic [7:0]       qb;
    logic [ACC_W-1:0] acc [N];
    int               ptr;

    always @(posedge clk) begin
        if (mac_clr) begin
            ptr <= 0;
        end else if (fifo_rden_b && ptr < DEPTH) begin
            for (int i = 0; i < N; i++) qa[i] <= fa[i][ptr];
            qb  <= fb[ptr];
            ptr <= ptr + 1;
        end
        for (int i = 0; i < N; i++) begin
            if (mac_clr)
                acc[i] <= '0;
            else if (mac_en)
                acc[i] <= acc[i] + ACC_W'(qa[i]) * ACC_W'(qb);
        end
    end

    always_comb begin
        mac_result = '0;
        for (int i = 0; i < N; i++) mac_result[i*ACC_W +: ACC_W] = acc[i];
    end

    // Cycle counter and event monitors
    int cyc = 0, rd_n = 0, fs_n = 0, last_rd = 0;
    always @(posedge clk) begin
        cyc <= cyc + 1;
        if (fifo_rden_b) begin
            rd_n    <= rd_n + 1;
            last_rd <= cyc;
        end
        if (fetch_start) fs_n <= fs_n + 1;
    end

    int n_chk = 0, n_fail = 0;
    int t0, rd0, fs0, off;

    task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (cycle offset %0d)", nm, act, exp, cyc - t0);
        end
    endtask

    task automatic load(input int mode);
        for (int k = 0; k < DEPTH; k++) begin
            fb[k] = (k < N) ? 8'(k + 1) : 8'hFF;
            for (int i = 0; i < N; i++)
                fa[i][k] = (k >= N) ? 8'hFF : (mode == 0) ? 8'(k + 1) : 8'(i + 1);
        end
    endtask

    function automatic int exp_lane(input int mode, input int i);
        return (mode == 0) ? 204 : (i + 1) * 36;
    endfunction

    task automatic check_lanes(input string nm, input int mode);
        for (int i = 0; i < N; i++)
            check(nm, 64'(result[i*ACC_W +: ACC_W]), 64'(exp_lane(mode, i)));
    endtask

    // Leaves the bench at the negedge of cycle t+1.
    task automatic go();
        @(negedge clk);
        start = 1'b1;
        t0  = cyc;
        rd0 = rd_n;
        fs0 = fs_n;
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic wait_end(input int maxc, output int o);
        o = -1;
        for (int k = 0; k < maxc; k++) begin
            if (done || error) begin
                o = cyc - t0;
                break;
            end
            @(negedge clk);
        end
    endtask

    function automatic logic [8:0] outs();
        return {busy, done, error, fetch_start, mac_clr, fifo_rden_b,
                &fifo_rden_a, |fifo_rden_a, mac_en};
    endfunction

    typedef struct {
        int         ofs;
        logic [8:0] exp;
    } vec_t;

    vec_t tbl [13];

    initial begin
        // {busy,done,error,fetch_start,mac_clr,rden_b,&rden_a,|rden_a,mac_en} per cycle after start
        tbl[0]  = '{1,  9'b1_0_0_1_1_0_0_0_0};
        tbl[1]  = '{2,  9'b1_0_0_0_0_0_0_0_0};
        tbl[2]  = '{3,  9'b1_0_0_0_0_1_1_1_0};
        tbl[3]  = '{4,  9'b1_0_0_0_0_1_1_1_1};
        tbl[4]  = '{5,  9'b1_0_0_0_0_1_1_1_1};
        tbl[5]  = '{6,  9'b1_0_0_0_0_1_1_1_1};
        tbl[6]  = '{7,  9'b1_0_0_0_0_1_1_1_1};
        tbl[7]  = '{8,  9'b1_0_0_0_0_1_1_1_1};
        tbl[8]  = '{9,  9'b1_0_0_0_0_1_1_1_1};
        tbl[9]  = '{10, 9'b1_0_0_0_0_1_1_1_1};
        tbl[10] = '{11, 9'b1_0_0_0_0_0_0_0_1};
        tbl[11] = '{12, 9'b1_0_0_0_0_0_0_0_0};
        tbl[12] = '{13, 9'b0_1_0_0_0_0_0_0_0};

        rst_n = 1'b0;
        start = 1'b0;
        fetch_done = 1'b0;
        fifo_empty_a = '0;
        fifo_empty_b = 1'b0;
        t0 = 0;
        load(0);
        #12;
        check("reset_outputs", 64'(outs()), 64'd0);
        check("reset_result", 64'(result[63:0]), 64'd0);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);

        // Nominal pass, cycle by cycle
        fetch_done = 1'b1;
        go();
        for (int r = 0; r < 13; r++) begin
            check($sformatf("nominal_t+%0d", tbl[r].ofs), 64'(outs()), 64'(tbl[r].exp));
            check($sformatf("nominal_ofs_%0d", r), 64'(cyc - t0), 64'(tbl[r].ofs));
            @(negedge clk);
        end
        check("nominal_reads", 64'(rd_n - rd0), 64'd8);
        check_lanes("nominal_lane", 0);

        // Stall: B FIFO empty for 3 cycles after the 4th read
        load(0);
        go();
        for (int k = 0; k < 20 && (rd_n - rd0) < 4; k++) @(negedge clk);
        check("stall_at_4", 64'(cyc - t0), 64'd7);
        fifo_empty_b = 1'b1;
        repeat (3) @(negedge clk);
        fifo_empty_b = 1'b0;
        wait_end(40, off);
        check("stall_done_ofs", 64'(off), 64'd16);
        check("stall_reads", 64'(rd_n - rd0), 64'd8);
        check("stall_last_read", 64'(last_rd - t0), 64'd13);
        check_lanes("stall_lane", 0);

        // Fetch timeout, then recovery
        fetch_done = 1'b0;
        go();
        wait_end(60, off);
        check("tmo_error_ofs", 64'(off), 64'd18);
        check("tmo_flags", 64'({busy, done, error}), 64'b001);
        check("tmo_reads", 64'(rd_n - rd0), 64'd0);
        fetch_done = 1'b1;
        load(0);
        go();
        check("tmo_error_drops", 64'(error), 64'd0);
        wait_end(40, off);
        check("recover_done_ofs", 64'(off), 64'd13);
        check("recover_flags", 64'({busy, done, error}), 64'b010);
        check_lanes("recover_lane", 0);

        // Start pulsed during STREAM is ignored
        go();
        repeat (4) @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        wait_end(40, off);
        check("busy_start_done_ofs", 64'(off), 64'd13);
        check("busy_start_fetch", 64'(fs_n - fs0), 64'd1);
        check("busy_start_reads", 64'(rd_n - rd0), 64'd8);

        // Reset mid-STREAM after 3 reads
        go();
        for (int k = 0; k < 20 && (rd_n - rd0) < 3; k++) @(negedge clk);
        rst_n = 1'b0;
        #1;
        check("rst_mid_outputs", 64'(outs()), 64'd0);
        check("rst_mid_result", 64'(result[63:0]), 64'd0);
        @(negedge clk);
        @(negedge clk);
        check("rst_mid_reads", 64'(rd_n - rd0), 64'd3);
        rst_n = 1'b1;
        go();
        wait_end(40, off);
        check("rst_rerun_done_ofs", 64'(off), 64'd13);
        check("rst_rerun_fetch", 64'(fs_n - fs0), 64'd1);
        check("rst_rerun_reads", 64'(rd_n - rd0), 64'd8);
        check_lanes("rst_rerun_lane", 0);

        // Back-to-back from DONE with new FIFO contents
        load(1);
        go();
        check("b2b_done_drop", 64'({done, mac_clr, fetch_start}), 64'b011);
        repeat (11) @(negedge clk);
        check("b2b_old_result", 64'(result[ACC_W-1:0]), 64'd204);
        wait_end(40, off);
        check("b2b_done_ofs", 64'(off), 64'd13);
        check_lanes("b2b_lane", 1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end
endmodule

// File: doc/matvec_sequencer.md
# matvec_sequencer

Top-level controller for the 8×8 matrix-vector engine. It starts the memory-to-FIFO fetch and waits for it to finish. It then drains the eight A-row FIFOs and the B FIFO in lockstep into the eight MAC lanes, waits out the MAC pipeline, and latches the eight accumulator results. It sits between the host start/done handshake, the data fetcher, the FIFO bank and the MAC array.

## Interface
Parameters:
- N, 8, number of MAC lanes, A-row FIFOs and elements per row
- ACC_W, 24, accumulator width per lane
- MAC_LAT, 1, cycles from the last mac_en cycle until mac_result holds the final sum
- FETCH_TIMEOUT, 1024, maximum cycles spent waiting for fetch_done

Ports:
- clk  in  1  clock, all logic on rising edge
- rst_n  in  1  reset, asynchronous, active-low
- start  in  1  one-cycle request to run one multiply
- busy  out  1  high in every state except IDLE, DONE and ERROR
- done  out  1  high while in DONE
- error  out  1  high while in ERROR (fetch timeout)
- fetch_start  out  1  one-cycle pulse to the data fetcher
- fetch_done  in  1  level from fetcher: all rows written to FIFOs
- fifo_empty_a  in  N  empty flag per A-row FIFO
- fifo_empty_b  in  1  empty flag of the B FIFO
- fifo_rden_a  out  N  read enable per A-row FIFO (all bits identical)
- fifo_rden_b  out  1  read enable of the B FIFO
- mac_clr  out  1  synchronous clear of all accumulators
- mac_en  out  1  accumulate enable; FIFO q is valid in this cycle
- mac_result  in  N*ACC_W  lane i at [i*ACC_W +: ACC_W]
- result  out  N*ACC_W  latched results, same packing

## Operation
- States: IDLE, CLEAR, FETCH, STREAM, FLUSH, DONE, ERROR.
- IDLE/DONE/ERROR with start=1 -> CLEAR. start is ignored in all other states.
- CLEAR (1 cycle): mac_clr=1, fetch_start=1. Clears rd_cnt and tmo_cnt. -> FETCH.
- FETCH: if fetch_done -> STREAM. Otherwise tmo_cnt increments. When tmo_cnt == FETCH_TIMEOUT-1 without fetch_done -> ERROR.
- STREAM: rd_ok = all fifo_empty_a low AND fifo_empty_b low.
  - fifo_rden_a = {N{rd_ok}} and fifo_rden_b = rd_ok while rd_cnt < N.
  - Each read increments rd_cnt (width clog2(N)+1).
  - A read with rd_cnt == N-1 -> FLUSH.
  - If rd_ok is low, reads stall. There is no timeout in STREAM.
- mac_en is fifo_rden_b registered one cycle, because FIFO q is valid the cycle after rden. It is independent of state.
- FLUSH: holds for MAC_LAT+1 cycles, counted by flush_cnt. On exit, result <= mac_result and the FSM goes to DONE.
- DONE: result holds until the next capture. ERROR: result unchanged.
- A new start from DONE runs a fresh pass. The previous result stays visible until the next capture.
- Reset values: state IDLE; busy, done, error, fetch_start, fifo_rden_a/b, mac_clr, mac_en all 0; result 0; all counters 0.
- Reset asserted mid-operation returns to IDLE immediately. No reads issue after reset.

## Timing
- start sampled at cycle t. CLEAR at t+1. FETCH from t+2.
- With fetch_done already high at t+2 and no stalls:
  - STREAM rden at t+3..t+3+N-1.
  - mac_en at t+4..t+N+3.
  - FLUSH at t+N+3..t+N+3+MAC_LAT.
  - done high from t+N+4+MAC_LAT. For defaults that is t+13.
- Each STREAM stall cycle adds exactly one cycle to done latency. mac_en gaps mirror rden gaps.
- At most N reads per pass, even if the FIFOs contain more data.
- done and error are levels. They drop in the cycle after start is accepted, when the FSM is in CLEAR.

## Test plan
- Nominal: FIFOs preloaded; A row i = {1..8}, B = {1..8}; fetch_done high at t+2; model MAC with MAC_LAT=1 -> 8 rden pulses at t+3..t+10, done at t+13, every lane of result = 204.
- Stall: raise fifo_empty_b for 3 cycles after the 4th read -> rden gap of 3 cycles, exactly 8 reads, done at t+16, results unchanged.
- Timeout: FETCH_TIMEOUT=16, fetch_done held low -> error high at t+18, no rden ever, busy low; a subsequent start with fetch_done high completes normally.
- Start while busy: pulse start during STREAM -> ignored; exactly one fetch_start and 8 reads.
- Reset mid-STREAM: assert rst_n low after 3 reads -> all outputs 0 immediately, state IDLE; a new start yields one fetch_start and 8 reads.
- Back-to-back: start in DONE -> done drops at t+1, mac_clr pulse, second pass result matches the new FIFO contents; old result visible until capture.
